// File: rtl/video_timing_gen_pkg.sv
// Mode tables and shared helpers for the video timing generator.
// Each mode entry holds the per-axis segment lengths and sync polarity.
package video_timing_pkg;

  typedef struct packed {
    int h_active;
    int h_fp;
    int h_sync;
    int h_bp;
    int v_active;
    int v_fp;
    int v_sync;
    int v_bp;
    bit hs_high;
    bit vs_high;
  } mode_t;

  localparam mode_t MODE_640X480_60  = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0};
  localparam mode_t MODE_800X600_60  = '{800, 40, 128, 88, 600, 1, 4, 23, 1'b1, 1'b1};
  localparam mode_t MODE_1280X720_60 = '{1280, 110, 40, 220, 720, 5, 5, 20, 1'b1, 1'b1};

  function automatic int seg_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/video_timing_gen_if.sv
// Timing generator control inputs and decoded timing outputs.
// master = generator side, slave = consumer/driver side.
interface video_timing_gen_if #(
  parameter int X_W  = 12,
  parameter int Y_W  = 11,
  parameter int PC_W = 21
);
  logic            i_en;
  logic            i_restart;
  logic            o_hsync;
  logic            o_vsync;
  logic            o_blank;
  logic            o_de;
  logic [X_W-1:0]  o_x;
  logic [Y_W-1:0]  o_y;
  logic [PC_W-1:0] o_pixel_count;
  logic            o_line_start;
  logic            o_frame_start;

  modport master (
    input  i_en, i_restart,
    output o_hsync, o_vsync, o_blank, o_de, o_x, o_y, o_pixel_count,
           o_line_start, o_frame_start
  );

  modport slave (
    output i_en, i_restart,
    input  o_hsync, o_vsync, o_blank, o_de, o_x, o_y, o_pixel_count,
           o_line_start, o_frame_start
  );
endinterface

// File: rtl/video_timing_gen_timing_axis.sv
// One timing axis: wrapping counter plus active/sync decode of the current count.
// wrap flags the terminal count; it is not gated by i_step.
module timing_axis
  import video_timing_pkg::*;
#(
  parameter int ACTIVE = 640,
  parameter int FP     = 16,
  parameter int SYNC   = 96,
  parameter int BP     = 48,
  parameter int W      = 12
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_restart,
  input  logic         i_step,
  output logic [W-1:0] count,
  output logic         wrap,
  output logic         active,
  output logic         sync_act
);

  localparam int TOTAL = seg_total(ACTIVE, FP, SYNC, BP);
  localparam logic [W-1:0] LAST       = W'(TOTAL - 1);
  localparam logic [W-1:0] ACTIVE_END = W'(ACTIVE);
  localparam logic [W-1:0] SYNC_START = W'(ACTIVE + FP);
  localparam logic [W-1:0] SYNC_END   = W'(ACTIVE + FP + SYNC);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (i_restart) begin
      count_d = '0;
    end else if (i_step) begin
      count_d = (count_q == LAST) ? '0 : count_q + W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count    = count_q;
  assign wrap     = (count_q == LAST);
  assign active   = (count_q < ACTIVE_END);
  assign sync_act = (count_q >= SYNC_START) && (count_q < SYNC_END);

endmodule

// File: rtl/video_timing_gen.sv
// Parametrised progressive-scan timing generator: sync/blank/de, coordinates and strobes.
// All outputs are registered one cycle behind the h/v/p counters; i_en=0 freezes everything.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int H_ACTIVE       = MODE_640X480_60.h_active,
  parameter int H_FP           = MODE_640X480_60.h_fp,
  parameter int H_SYNC         = MODE_640X480_60.h_sync,
  parameter int H_BP           = MODE_640X480_60.h_bp,
  parameter int V_ACTIVE       = MODE_640X480_60.v_active,
  parameter int V_FP           = MODE_640X480_60.v_fp,
  parameter int V_SYNC         = MODE_640X480_60.v_sync,
  parameter int V_BP           = MODE_640X480_60.v_bp,
  parameter int HS_ACTIVE_HIGH = 0,
  parameter int VS_ACTIVE_HIGH = 0,
  parameter int X_W            = 12,
  parameter int Y_W            = 11,
  parameter int PC_W           = 21
) (
  input  logic                i_clk,
  input  logic                i_rst,
  video_timing_gen_if.master  vid
);

  localparam int     H_TOTAL     = seg_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int     V_TOTAL     = seg_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam longint FRAME_TOTAL = longint'(H_TOTAL) * longint'(V_TOTAL);
  localparam logic   HS_ON       = (HS_ACTIVE_HIGH != 0);
  localparam logic   VS_ON       = (VS_ACTIVE_HIGH != 0);

  if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
      V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0 ||
      X_W == 0 || Y_W == 0 || PC_W == 0) begin : g_bad_zero
    $error("video_timing_gen: zero-valued parameter");
  end
  if (longint'(H_TOTAL) > (longint'(1) << X_W)) begin : g_bad_xw
    $error("video_timing_gen: H_TOTAL does not fit X_W");
  end
  if (longint'(V_TOTAL) > (longint'(1) << Y_W)) begin : g_bad_yw
    $error("video_timing_gen: V_TOTAL does not fit Y_W");
  end
  if (FRAME_TOTAL > (longint'(1) << PC_W)) begin : g_bad_pcw
    $error("video_timing_gen: H_TOTAL*V_TOTAL does not fit PC_W");
  end

  logic [X_W-1:0]  h_count;
  logic [Y_W-1:0]  v_count;
  logic            h_wrap, v_wrap, h_active, v_active, h_sync_act, v_sync_act;
  logic            v_step;
  logic [PC_W-1:0] p_q, p_d;

  assign v_step = vid.i_en && h_wrap;

  timing_axis #(.ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .W(X_W)) u_h_axis (
    .i_clk(i_clk), .i_rst(i_rst), .i_restart(vid.i_restart), .i_step(vid.i_en),
    .count(h_count), .wrap(h_wrap), .active(h_active), .sync_act(h_sync_act)
  );

  timing_axis #(.ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .W(Y_W)) u_v_axis (
    .i_clk(i_clk), .i_rst(i_rst), .i_restart(vid.i_restart), .i_step(v_step),
    .count(v_count), .wrap(v_wrap), .active(v_active), .sync_act(v_sync_act)
  );

  always_comb begin
    p_d = p_q;
    if (vid.i_restart) begin
      p_d = '0;
    end else if (vid.i_en) begin
      p_d = (h_wrap && v_wrap) ? '0 : p_q + PC_W'(1);
    end
  end

  logic            hsync_q, hsync_d, vsync_q, vsync_d, blank_q, blank_d;
  logic            line_start_q, line_start_d, frame_start_q, frame_start_d;
  logic [X_W-1:0]  x_q, x_d;
  logic [Y_W-1:0]  y_q, y_d;
  logic [PC_W-1:0] pc_q, pc_d;

  always_comb begin
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    blank_d       = blank_q;
    x_d           = x_q;
    y_d           = y_q;
    pc_d          = pc_q;
    line_start_d  = line_start_q;
    frame_start_d = frame_start_q;
    if (vid.i_restart) begin
      // Pixel (0,0) is always active and never inside a sync pulse.
      hsync_d       = ~HS_ON;
      vsync_d       = ~VS_ON;
      blank_d       = 1'b0;
      x_d           = '0;
      y_d           = '0;
      pc_d          = '0;
      line_start_d  = 1'b1;
      frame_start_d = 1'b1;
    end else if (vid.i_en) begin
      hsync_d       = h_sync_act ~^ HS_ON;
      vsync_d       = v_sync_act ~^ VS_ON;
      blank_d       = !(h_active && v_active);
      x_d           = h_count;
      y_d           = v_count;
      pc_d          = p_q;
      line_start_d  = (h_count == '0);
      frame_start_d = (h_count == '0) && (v_count == '0);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      p_q           <= '0;
      hsync_q       <= ~HS_ON;
      vsync_q       <= ~VS_ON;
      blank_q       <= 1'b1;
      x_q           <= '0;
      y_q           <= '0;
      pc_q          <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      p_q           <= p_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      blank_q       <= blank_d;
      x_q           <= x_d;
      y_q           <= y_d;
      pc_q          <= pc_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign vid.o_hsync       = hsync_q;
  assign vid.o_vsync       = vsync_q;
  assign vid.o_blank       = blank_q;
  assign vid.o_de          = ~blank_q;
  assign vid.o_x           = x_q;
  assign vid.o_y           = y_q;
  assign vid.o_pixel_count = pc_q;
  assign vid.o_line_start  = line_start_q;
  assign vid.o_frame_start = frame_start_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Two generator instances (small active-high mode, medium active-low mode) driven by shared
// random en/restart/reset stimulus and scoreboarded against a linear-position model.
module tb_video_timing_gen;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        blank;
    logic        de;
    logic [11:0] x;
    logic [10:0] y;
    logic [20:0] pc;
    logic        ls;
    logic        fs;
  } obs_t;

  localparam int TOT_S = 15 * 7;
  localparam int TOT_M = 32 * 13;

  logic clk = 1'b0;
  logic rst, en, restart;
  int   checks = 0;
  int   failures = 0;
  int   cycle = 0;

  always #5 clk = ~clk;

  video_timing_gen_if #(.X_W(12), .Y_W(11), .PC_W(21)) if_s ();
  video_timing_gen_if #(.X_W(12), .Y_W(11), .PC_W(21)) if_m ();

  assign if_s.i_en      = en;
  assign if_s.i_restart = restart;
  assign if_m.i_en      = en;
  assign if_m.i_restart = restart;

  video_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_ACTIVE_HIGH(1), .VS_ACTIVE_HIGH(1), .X_W(12), .Y_W(11), .PC_W(21)
  ) dut_s (.i_clk(clk), .i_rst(rst), .vid(if_s));

  video_timing_gen #(
    .H_ACTIVE(20), .H_FP(3), .H_SYNC(4), .H_BP(5),
    .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .HS_ACTIVE_HIGH(0), .VS_ACTIVE_HIGH(0), .X_W(12), .Y_W(11), .PC_W(21)
  ) dut_m (.i_clk(clk), .i_rst(rst), .vid(if_m));

  // Expected outputs for a linear frame position; h and v come from div/mod.
  function automatic obs_t decode(int pos, int ha, int hf, int hsw, int hb,
                                  int va, int vf, int vsw, bit hp, bit vp);
    obs_t o;
    int ht = ha + hf + hsw + hb;
    int h  = pos % ht;
    int v  = pos / ht;
    bit hs_on = (h >= ha + hf) && (h < ha + hf + hsw);
    bit vs_on = (v >= va + vf) && (v < va + vf + vsw);
    o.hs    = hp ? hs_on : !hs_on;
    o.vs    = vp ? vs_on : !vs_on;
    o.blank = !((h < ha) && (v < va));
    o.de    = !o.blank;
    o.x     = 12'(h);
    o.y     = 11'(v);
    o.pc    = 21'(pos);
    o.ls    = (h == 0);
    o.fs    = (pos == 0);
    return o;
  endfunction

  function automatic obs_t dec_s(int pos);
    return decode(pos, 8, 2, 3, 2, 4, 1, 1, 1'b1, 1'b1);
  endfunction

  function automatic obs_t dec_m(int pos);
    return decode(pos, 20, 3, 4, 5, 6, 2, 2, 1'b0, 1'b0);
  endfunction

  function automatic obs_t reset_obs(bit hp, bit vp);
    obs_t o = '0;
    o.hs    = !hp;
    o.vs    = !vp;
    o.blank = 1'b1;
    return o;
  endfunction

  obs_t q_s[$];
  obs_t q_m[$];
  int   pos_s = 0, pos_m = 0;
  obs_t exp_s = '0, exp_m = '0;

  // Drive one cycle of inputs, advance the model across the coming edge, queue the result.
  task automatic apply(input logic r, input logic rs, input logic e);
    rst     = r;
    restart = rs;
    en      = e;
    if (r) begin
      pos_s = 0;  exp_s = reset_obs(1'b1, 1'b1);
      pos_m = 0;  exp_m = reset_obs(1'b0, 1'b0);
    end else if (rs) begin
      pos_s = 0;  exp_s = dec_s(0);
      pos_m = 0;  exp_m = dec_m(0);
    end else if (e) begin
      exp_s = dec_s(pos_s);  pos_s = (pos_s + 1) % TOT_S;
      exp_m = dec_m(pos_m);  pos_m = (pos_m + 1) % TOT_M;
    end
    q_s.push_back(exp_s);
    q_m.push_back(exp_m);
    @(posedge clk);
    #1;
  endtask

  function automatic obs_t sample(input logic hs, vs, bl, de, input logic [11:0] x,
                                  input logic [10:0] y, input logic [20:0] pc,
                                  input logic ls, fs);
    return '{hs, vs, bl, de, x, y, pc, ls, fs};
  endfunction

  task automatic compare(input string name, input obs_t act, input obs_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got hs=%b vs=%b bl=%b de=%b x=%0d y=%0d pc=%0d ls=%b fs=%b want hs=%b vs=%b bl=%b de=%b x=%0d y=%0d pc=%0d ls=%b fs=%b",
               name, cycle, act.hs, act.vs, act.blank, act.de, act.x, act.y, act.pc, act.ls, act.fs,
               exp.hs, exp.vs, exp.blank, exp.de, exp.x, exp.y, exp.pc, exp.ls, exp.fs);
    end
  endtask

  initial begin : monitor
    forever begin
      @(posedge clk);
      #3;
      cycle++;
      if (q_s.size() > 0) begin
        compare("small", sample(if_s.o_hsync, if_s.o_vsync, if_s.o_blank, if_s.o_de, if_s.o_x,
                                if_s.o_y, if_s.o_pixel_count, if_s.o_line_start,
                                if_s.o_frame_start), q_s.pop_front());
      end
      if (q_m.size() > 0) begin
        compare("medium", sample(if_m.o_hsync, if_m.o_vsync, if_m.o_blank, if_m.o_de, if_m.o_x,
                                 if_m.o_y, if_m.o_pixel_count, if_m.o_line_start,
                                 if_m.o_frame_start), q_m.pop_front());
      end
    end
  end

  initial begin : stimulus
    repeat (3) apply(1'b1, 1'b0, 1'b1);
    repeat (2 * TOT_M + 5) apply(1'b0, 1'b0, 1'b1);
    repeat (17) apply(1'b0, 1'b0, 1'b0);
    repeat (40) apply(1'b0, 1'b0, 1'b1);
    apply(1'b0, 1'b1, 1'b0);
    repeat (30) apply(1'b0, 1'b0, 1'b1);
    apply(1'b1, 1'b1, 1'b1);
    repeat (30) apply(1'b0, 1'b0, 1'b1);
    repeat (5) apply(1'b0, 1'b1, 1'b1);
    repeat (TOT_S + 3) apply(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5000; i++) begin
      logic r, rs, e;
      r  = ($urandom_range(0, 399) == 0);
      rs = ($urandom_range(0, 79) == 0);
      e  = ($urandom_range(0, 7) != 0);
      apply(r, rs, e);
    end
    repeat (3) @(posedge clk);
    #4;
    checks++;
    if (q_s.size() != 0 || q_m.size() != 0) begin
      failures++;
      $display("FAIL drain got small=%0d medium=%0d pending want 0", q_s.size(), q_m.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Parametrised successor to the fixed 640x480 timing and pixel-counter pair in the DVI transmit path.
- Runs in the pixel clock domain and drives the pattern generator and rgb_to_dvi encoder.
- Generates hsync, vsync, blank and data-enable for any CEA/VESA progressive mode, with configurable sync polarity.
- Exposes raw x/y coordinates, a linear pixel index and line/frame strobes, with run-time pause and resynchronise controls.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- HS_ACTIVE_HIGH, 0, 1 = hsync asserted high; 0 = asserted low
- VS_ACTIVE_HIGH, 0, 1 = vsync asserted high; 0 = asserted low
- X_W, 12, width of x coordinate
- Y_W, 11, width of y coordinate
- PC_W, 21, width of linear pixel index

Ports:
- i_clk  in  1  pixel clock; sole clock
- i_rst  in  1  synchronous, active-high reset
- i_en  in  1  1 = advance one pixel per cycle; 0 = hold all state
- i_restart  in  1  synchronous resync: return to pixel (0,0)
- o_hsync  out  1  horizontal sync, polarity per HS_ACTIVE_HIGH
- o_vsync  out  1  vertical sync, polarity per VS_ACTIVE_HIGH
- o_blank  out  1  1 outside active region
- o_de  out  1  inverse of o_blank
- o_x  out  X_W  horizontal counter, 0..H_TOTAL-1
- o_y  out  Y_W  vertical counter, 0..V_TOTAL-1
- o_pixel_count  out  PC_W  linear index, 0..H_TOTAL*V_TOTAL-1
- o_line_start  out  1  one-cycle strobe when x==0
- o_frame_start  out  1  one-cycle strobe when x==0 and y==0

Behaviour:
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- Elaboration-time error if H_TOTAL > 2^X_W, V_TOTAL > 2^Y_W, H_TOTAL*V_TOTAL > 2^PC_W, or any parameter is zero.
- Internal counters h, v, p. When i_en=1:
  - h increments; wraps H_TOTAL-1 -> 0.
  - On h wrap, v increments; wraps V_TOTAL-1 -> 0.
  - p increments; wraps at H_TOTAL*V_TOTAL-1 -> 0, coincident with the (h,v) wrap.
- Decode, combinational from counters:
  - active = (h < H_ACTIVE) && (v < V_ACTIVE)
  - hs_act = H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC
  - vs_act = V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC; whole lines, so edges align with h==0
- All outputs are registered from the decode: fixed latency of 1 cycle from counter state to output. o_x/o_y/o_pixel_count carry the same 1-cycle latency, so they stay aligned with the sync and blank outputs.
- Polarity: o_hsync = hs_act XNOR HS_ACTIVE_HIGH; o_vsync likewise with VS_ACTIVE_HIGH.
- Reset (i_rst=1):
  - Counters go to 0.
  - Outputs: o_hsync = ~HS_ACTIVE_HIGH, o_vsync = ~VS_ACTIVE_HIGH, o_blank=1, o_de=0, o_x=0, o_y=0, o_pixel_count=0, o_line_start=0, o_frame_start=0.
  - On the first cycle after reset release, the outputs present pixel (0,0) (o_frame_start=1, o_de=1) when i_en=1.
- i_en=0: counters and every output register hold their values, strobes included. A strobe is therefore held, not re-pulsed.
- i_restart=1: counters load 0 regardless of i_en. The next cycle the outputs present (0,0) with o_frame_start=1. Asserting i_restart mid-frame truncates that frame.
- Priority: i_rst > i_restart > i_en.
- Sustained i_restart holds the block at (0,0), with o_frame_start asserted every cycle.
- Reset asserted mid-frame takes effect on the next edge; no partial-state retention.

Decomposition:
- Package video_timing_pkg holds:
  - localparam sets for supported modes (640x480@60, 800x600@60, 1280x720@60): H/V active, porch and sync values plus polarities.
  - A function computing the total from the four segment values.
- One sub-module, timing_axis, instantiated twice (horizontal and vertical):
  - Parameters: ACTIVE, FP, SYNC, BP, W.
  - Inputs: i_clk, i_rst, i_restart, i_step.
  - Outputs: count, wrap, active, sync_act.
  - The vertical instance's i_step = i_en && horizontal wrap.

Test Plan:
- Reset: hold i_rst 3 cycles with i_en=1 -> o_blank=1, o_de=0, o_hsync=1, o_vsync=1 (defaults active-low), counters 0. First cycle after release -> o_x=0, o_y=0, o_frame_start=1.
- Default full frame: run 420000 cycles ->
  - o_frame_start pulses exactly every 420000 cycles and o_line_start every 800.
  - o_hsync low for exactly 96 cycles starting at o_x=656.
  - o_vsync low for lines 490-491 (1600 cycles).
  - o_de count per frame = 307200.
  - o_pixel_count wraps 419999 -> 0 together with o_frame_start.
- Small mode: H 8/2/3/2, V 4/1/1/1, HS_ACTIVE_HIGH=1, VS_ACTIVE_HIGH=1 -> H_TOTAL=15, V_TOTAL=7; o_hsync high at x=10..12; o_vsync high on line y=5; frame period 105 cycles.
- Enable hold: deassert i_en for 17 cycles at o_x=100 -> all outputs frozen for those 17 cycles; on resume, o_x steps to 101; frame period grows by 17.
- Restart mid-frame: pulse i_restart at o_y=200, with i_en=0 on the same cycle -> next cycle o_x=0, o_y=0, o_pixel_count=0, o_frame_start=1. Also pulse i_rst together with i_restart -> reset output values win.
- Elaboration guard: X_W=9 with H_TOTAL=800 -> elaboration fails.
